fma16_vector_checker: RTL

- Self-checking harness stage for the half-precision FMA datapath.
- Accepts packed 76-bit test vectors over a valid/ready stream and drives the combinational fma16 operand/control ports from a stage register.
- Compares fma16 result (and optionally flags) against the expected fields, then accumulates vector/error counts and captures the first failure.
- Sits between a vector source (ROM/DMA/UART loader) and fma16; serves FPGA bring-up and synthesizable regression.

---
 rtl/fma16_vector_checker.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/fma16_vector_checker.sv
// fma16_vector_checker: self-checking harness stage for the fma16 datapath.
// Accepts packed test vectors over valid/ready, drives fma16 operands and
// controls from a stage register, and compares the result against the expected
// value. It also keeps vector and error counts and captures the first failure.
// Optional feature: define FMA16_FLAG_CHECK_EN to compare fma16 flags against
// fexp as well and to expose first_err_flags / first_err_flags_expected.
module fma16_vector_checker #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [75:0]      vec_data,
    input  logic             vec_last,
    output logic [15:0]      fma_x,
    output logic [15:0]      fma_y,
    output logic [15:0]      fma_z,
    output logic             fma_mul,
    output logic             fma_add,
    output logic             fma_negp,
    output logic             fma_negz,
    output logic [1:0]       fma_roundmode,
    input  logic [15:0]      fma_result,
    input  logic [3:0]       fma_flags,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [15:0]      first_err_result,
    output logic [15:0]      first_err_expected
`ifdef FMA16_FLAG_CHECK_EN
    ,
    output logic [3:0]       first_err_flags,
    output logic [3:0]       first_err_flags_expected
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic             r_s_vld;
    logic             r_last_seen;
    logic [15:0]      r_x;
    logic [15:0]      r_y;
    logic [15:0]      r_z;
    logic [5:0]       r_ctrl;
    logic [15:0]      r_rexp;
    logic [CNT_W-1:0] r_vec_count;
    logic [CNT_W-1:0] r_err_count;
    logic             r_first_err_valid;
    logic [CNT_W-1:0] r_first_err_idx;
    logic [15:0]      r_first_err_result;
    logic [15:0]      r_first_err_expected;
    logic             w_mismatch;
    logic             w_load;

`ifdef FMA16_FLAG_CHECK_EN
    logic [3:0]       r_fexp;
    logic [3:0]       r_first_err_flags;
    logic [3:0]       r_first_err_flags_exp;
    logic             w_unused;

    assign w_unused   = ^vec_data[27:26];
    assign w_mismatch = (fma_result != r_rexp) || (fma_flags != r_fexp);
    assign first_err_flags          = r_first_err_flags;
    assign first_err_flags_expected = r_first_err_flags_exp;
`else
    logic             w_unused;

    assign w_unused   = ^{vec_data[27:26], vec_data[3:0], fma_flags};
    assign w_mismatch = (fma_result != r_rexp);
`endif

    assign w_load = vec_valid && vec_ready;

    assign fma_x         = r_x;
    assign fma_y         = r_y;
    assign fma_z         = r_z;
    assign fma_roundmode = r_ctrl[5:4];
    assign fma_mul       = r_ctrl[3];
    assign fma_add       = r_ctrl[2];
    assign fma_negp      = r_ctrl[1];
    assign fma_negz      = r_ctrl[0];

    assign vec_count          = r_vec_count;
    assign err_count          = r_err_count;
    assign first_err_valid    = r_first_err_valid;
    assign first_err_idx      = r_first_err_idx;
    assign first_err_result   = r_first_err_result;
    assign first_err_expected = r_first_err_expected;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic; the run ends when the stage holding the last vector is evaluated
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next_state = ST_RUN;
            ST_RUN:  if (r_s_vld && r_last_seen) w_next_state = ST_DONE;
            ST_DONE: if (start) w_next_state = ST_RUN;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy      = (r_state == ST_RUN);
        done      = (r_state == ST_DONE);
        vec_ready = (r_state == ST_RUN) && !r_last_seen;
        pass      = (r_state == ST_DONE) && (r_err_count == '0);
    end

    // Stage register, evaluation of the staged vector, counters and first-failure capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s_vld              <= 1'b0;
            r_last_seen          <= 1'b0;
            r_x                  <= '0;
            r_y                  <= '0;
            r_z                  <= '0;
            r_ctrl               <= '0;
            r_rexp               <= '0;
            r_vec_count          <= '0;
            r_err_count          <= '0;
            r_first_err_valid    <= 1'b0;
            r_first_err_idx      <= '0;
            r_first_err_result   <= '0;
            r_first_err_expected <= '0;
`ifdef FMA16_FLAG_CHECK_EN
            r_fexp                <= '0;
            r_first_err_flags     <= '0;
            r_first_err_flags_exp <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_s_vld              <= 1'b0;
                        r_last_seen          <= 1'b0;
                        r_vec_count          <= '0;
                        r_err_count          <= '0;
                        r_first_err_valid    <= 1'b0;
                        r_first_err_idx      <= '0;
                        r_first_err_result   <= '0;
                        r_first_err_expected <= '0;
`ifdef FMA16_FLAG_CHECK_EN
                        r_first_err_flags     <= '0;
                        r_first_err_flags_exp <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    if (r_s_vld) begin
                        if (r_vec_count != '1) r_vec_count <= r_vec_count + CNT_W'(1);
                        if (w_mismatch) begin
                            if (r_err_count != '1) r_err_count <= r_err_count + CNT_W'(1);
                            if (!r_first_err_valid) begin
                                r_first_err_valid    <= 1'b1;
                                r_first_err_idx      <= r_vec_count;
                                r_first_err_result   <= fma_result;
                                r_first_err_expected <= r_rexp;
`ifdef FMA16_FLAG_CHECK_EN
                                r_first_err_flags     <= fma_flags;
                                r_first_err_flags_exp <= r_fexp;
`endif
                            end
                        end
                    end
                    if (w_load) begin
                        r_s_vld <= 1'b1;
                        r_x     <= vec_data[75:60];
                        r_y     <= vec_data[59:44];
                        r_z     <= vec_data[43:28];
                        r_ctrl  <= vec_data[25:20];
                        r_rexp  <= vec_data[19:4];
`ifdef FMA16_FLAG_CHECK_EN
                        r_fexp  <= vec_data[3:0];
`endif
                        if (vec_last) r_last_seen <= 1'b1;
                    end else begin
                        r_s_vld <= 1'b0;
                    end
                end
                default: r_s_vld <= 1'b0;
            endcase
        end
    end

endmodule
